axis_packet_sender: RTL and testbench

AXIS_PACKET_SENDER -- requirements
Module: axis_packet_sender

---
 rtl/axis_packet_sender.sv | 163 ++++++++++++++++
 tb/tb_axis_packet_sender.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_sender.sv
// axis_packet_sender: holds a packet in an internal word buffer that is filled
// through a simple write port, then replays it as an AXI-Stream burst when
// started. The stream outputs come straight from flops. The next word is read
// from the buffer on each accepted beat, so a downstream that is always ready
// receives one beat per cycle.
module axis_packet_sender #(
    parameter int DATA_WIDTH        = 32,
    parameter int STORAGE_IDX_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wrEn,
    input  logic [STORAGE_IDX_WIDTH-1:0] wrAddr,
    input  logic [DATA_WIDTH-1:0]        wrData,
    input  logic [STORAGE_IDX_WIDTH:0]   pktLen,
    input  logic                         sendInit,
    input  logic                         sendReset,
    output logic [DATA_WIDTH-1:0]        M_AXI_TDATA,
    output logic [DATA_WIDTH/8-1:0]      M_AXI_TKEEP,
    output logic                         M_AXI_TVALID,
    input  logic                         M_AXI_TREADY,
    output logic                         M_AXI_TLAST,
    output logic                         busy,
    output logic                         finSend,
    output logic                         lenErr
);

    localparam int          IW    = STORAGE_IDX_WIDTH;
    localparam int          KW    = DATA_WIDTH / 8;
    localparam logic [IW:0] DEPTH = {1'b1, {IW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } state_t;

    logic [DATA_WIDTH-1:0] mem [0:(1<<IW)-1];
    logic [DATA_WIDTH-1:0] tdata_q;

    state_t        state_q,    state_d;
    logic [IW-1:0] beat_cnt_q, beat_cnt_d;
    logic [IW:0]   len_q,      len_d;
    logic          tvalid_q,   tvalid_d;
    logic          tlast_q,    tlast_d;
    logic          fin_q,      fin_d;
    logic          len_err_q,  len_err_d;

    logic          load_en;
    logic [IW-1:0] rd_idx;
    logic [IW:0]   next_beat;
    logic          len_ok;
    logic          beat_acc;

    // The beat counter never exceeds DEPTH-1. The compare for the next beat is
    // done one bit wider so that a full-depth packet ends exactly on beat DEPTH-1.
    assign next_beat = {1'b0, beat_cnt_q} + (IW+1)'(1);
    assign len_ok    = (pktLen != '0) && (pktLen <= DEPTH);
    assign beat_acc  = tvalid_q && M_AXI_TREADY;

    // Next-state logic: sequencing, the load strobe for the stream data and the sticky flags.
    // NOTE: every signal driven here gets a default first, so no path can leave a latch behind.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        fin_d      = fin_q;
        len_err_d  = len_err_q;
        load_en    = 1'b0;
        rd_idx     = '0;

        if (sendReset) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            tvalid_d   = 1'b0;
            tlast_d    = 1'b0;
            fin_d      = 1'b0;
            len_err_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sendInit) begin
                        if (len_ok) begin
                            len_d      = pktLen;
                            fin_d      = 1'b0;
                            beat_cnt_d = '0;
                            state_d    = FETCH;
                        end else begin
                            len_err_d  = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    load_en  = 1'b1;
                    rd_idx   = '0;
                    tvalid_d = 1'b1;
                    tlast_d  = (len_q == (IW+1)'(1));
                    state_d  = SEND;
                end
                SEND: begin
                    if (beat_acc) begin
                        if (tlast_q) begin
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            fin_d    = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            load_en    = 1'b1;
                            rd_idx     = next_beat[IW-1:0];
                            beat_cnt_d = next_beat[IW-1:0];
                            tlast_d    = ((next_beat + (IW+1)'(1)) == len_q);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control and output flops. An asynchronous reset returns the block to an idle, silent state at once.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            len_q      <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            fin_q      <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            fin_q      <= fin_d;
            len_err_q  <= len_err_d;
        end
    end

    // Buffer write port (IDLE only) and the synchronous read into the stream data register.
    // NOTE: the buffer and data register are deliberately unreset so they can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wrEn && (state_q == IDLE)) begin
            mem[wrAddr] <= wrData;
        end
        if (load_en) begin
            tdata_q <= mem[rd_idx];
        end
    end

    assign M_AXI_TDATA  = tdata_q;
    assign M_AXI_TKEEP  = {KW{tvalid_q}};
    assign M_AXI_TVALID = tvalid_q;
    assign M_AXI_TLAST  = tlast_q;
    assign busy         = (state_q != IDLE);
    assign finSend      = fin_q;
    assign lenErr       = len_err_q;

endmodule

// File: tb/tb_axis_packet_sender.sv
// tb_axis_packet_sender: randomized self-checking bench. A plain array mirrors
// the buffer contents. Each packet is expected to deliver model_mem[0..len-1]
// in order, with TLAST only on the final beat and with the data held while the
// stream is stalled.
module tb_axis_packet_sender;

    localparam int DW    = 32;
    localparam int IW    = 10;
    localparam int DEPTH = 1 << IW;

    logic            clk;
    logic            reset;
    logic            wrEn;
    logic [IW-1:0]   wrAddr;
    logic [DW-1:0]   wrData;
    logic [IW:0]     pktLen;
    logic            sendInit;
    logic            sendReset;
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tvalid;
    logic            tready;
    logic            tlast;
    logic            busy;
    logic            finSend;
    logic            lenErr;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]   model_mem [DEPTH];
    logic [DW/8-1:0] all_keep = '1;

    axis_packet_sender #(
        .DATA_WIDTH       (DW),
        .STORAGE_IDX_WIDTH(IW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wrEn        (wrEn),
        .wrAddr      (wrAddr),
        .wrData      (wrData),
        .pktLen      (pktLen),
        .sendInit    (sendInit),
        .sendReset   (sendReset),
        .M_AXI_TDATA (tdata),
        .M_AXI_TKEEP (tkeep),
        .M_AXI_TVALID(tvalid),
        .M_AXI_TREADY(tready),
        .M_AXI_TLAST (tlast),
        .busy        (busy),
        .finSend     (finSend),
        .lenErr      (lenErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int addr, input logic [DW-1:0] data);
        wrEn   = 1'b1;
        wrAddr = IW'(addr);
        wrData = data;
        tick();
        wrEn   = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tvalid"}, tvalid, 1'b0);
        check({tag, "_tlast"},  tlast,  1'b0);
        check({tag, "_tkeep"},  tkeep,  '0);
        check({tag, "_busy"},   busy,   1'b0);
    endtask

    // ready_mode: 1 = always ready, 2 = 1,0,0 repeating, other = random.
    // poke_cyc pulses sendInit mid-packet, which must be ignored.
    // wr_cyc writes inverted data to the last word mid-packet, which must also be ignored.
    task automatic run_packet(input int len, input int ready_mode, input int poke_cyc, input int wr_cyc);
        int            beats;
        int            cyc;
        bit            done;
        logic          pv;
        logic          pr;
        logic          pl;
        logic [DW-1:0] pd;
        logic          r;

        pktLen   = (IW+1)'(len);
        sendInit = 1'b1;
        tick();
        sendInit = 1'b0;
        check("fetch_tvalid", tvalid, 1'b0);
        check("fetch_busy",   busy,   1'b1);
        tick();
        check("tvalid_latency", tvalid, 1'b1);

        beats = 0;
        cyc   = 0;
        done  = 1'b0;
        pv    = 1'b0;
        pr    = 1'b0;
        pl    = 1'b0;
        pd    = '0;
        while (!done && cyc < len * 4 + 50) begin
            case (ready_mode)
                1:       r = 1'b1;
                2:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            tready = r;
            if (cyc == poke_cyc) begin
                sendInit = 1'b1;
                pktLen   = (IW+1)'(1);
            end
            if (cyc == wr_cyc) begin
                wrEn   = 1'b1;
                wrAddr = IW'(len - 1);
                wrData = ~model_mem[len - 1];
            end
            check("tvalid_held", tvalid, 1'b1);
            check("tkeep_valid", tkeep,  all_keep);
            if (pv && !pr) begin
                check("stall_data", tdata, pd);
                check("stall_last", tlast, pl);
            end
            if (tvalid && r) begin
                check("beat_data", tdata, model_mem[beats]);
                check("beat_last", tlast, (beats == len - 1));
                beats++;
                if (beats == len) done = 1'b1;
            end
            pv = tvalid;
            pr = r;
            pd = tdata;
            pl = tlast;
            tick();
            sendInit = 1'b0;
            wrEn     = 1'b0;
            cyc++;
        end
        tready = 1'b0;
        check("packet_done",  done,  1'b1);
        check("beat_count",   beats, len);
        if (ready_mode == 1) check("no_bubble_cycles", cyc, len);
        check_idle("after_last");
        check("fin_after_last", finSend, 1'b1);
    endtask

    initial begin
        int bad_len [2];
        int len;
        int poke;

        reset     = 1'b0;
        wrEn      = 1'b0;
        wrAddr    = '0;
        wrData    = '0;
        pktLen    = '0;
        sendInit  = 1'b0;
        sendReset = 1'b0;
        tready    = 1'b0;

        // Outputs while reset is held low.
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_fin",    finSend, 1'b0);
        check("reset_lenerr", lenErr,  1'b0);
        #2 reset = 1'b1;
        tick();

        // Fill the whole buffer with random words, then the known A0..A3 header.
        for (int i = 0; i < DEPTH; i++) write_word(i, $urandom());
        for (int i = 0; i < 4; i++) write_word(i, DW'(32'hA0 + i));

        // Basic 4-beat packet with ready always high.
        run_packet(4, 1, -1, -1);
        check("basic_busy", busy, 1'b0);

        // Same packet with a 1,0,0 ready pattern and a write attempted during SEND.
        run_packet(4, 2, -1, 0);

        // Resend the unchanged buffer.
        run_packet(4, 1, -1, -1);

        // Single-beat packet.
        run_packet(1, 1, -1, -1);

        // sendReset clears finSend.
        sendReset = 1'b1;
        tick();
        sendReset = 1'b0;
        check("sreset_fin", finSend, 1'b0);

        // Illegal lengths set lenErr and never start a packet.
        bad_len[0] = 0;
        bad_len[1] = DEPTH + 1;
        for (int i = 0; i < 2; i++) begin
            pktLen   = (IW+1)'(bad_len[i]);
            sendInit = 1'b1;
            tick();
            sendInit = 1'b0;
            check("lenerr_set", lenErr, 1'b1);
            check("lenerr_busy", busy, 1'b0);
            tick();
            check_idle("lenerr");
            sendReset = 1'b1;
            tick();
            sendReset = 1'b0;
            check("lenerr_clear", lenErr, 1'b0);
        end

        // sendReset wins over sendInit in the same cycle.
        pktLen    = (IW+1)'(4);
        sendInit  = 1'b1;
        sendReset = 1'b1;
        tick();
        sendInit  = 1'b0;
        sendReset = 1'b0;
        check("both_busy", busy, 1'b0);
        tick();
        check_idle("both");

        // Full-depth packet.
        run_packet(DEPTH, 1, -1, -1);

        // Abort after two beats of an 8-beat packet, with the stream stalled.
        pktLen   = (IW+1)'(8);
        sendInit = 1'b1;
        tick();
        sendInit = 1'b0;
        tick();
        for (int b = 0; b < 2; b++) begin
            tready = 1'b1;
            check("abort_pre_data", tdata, model_mem[b]);
            tick();
        end
        tready    = 1'b0;
        sendReset = 1'b1;
        tick();
        sendReset = 1'b0;
        check_idle("abort");
        check("abort_fin", finSend, 1'b0);
        run_packet(8, 1, -1, -1);

        // Random lengths, random ready, random rewrites, and occasional ignored sendInit.
        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < 3; w++) write_word($urandom_range(0, 47), $urandom());
            len  = $urandom_range(1, 48);
            poke = (it % 2 == 1) ? $urandom_range(0, len - 1) : -1;
            run_packet(len, 3, poke, -1);
        end

        // Asynchronous reset in the middle of a packet.
        pktLen   = (IW+1)'(8);
        sendInit = 1'b1;
        tick();
        sendInit = 1'b0;
        tick();
        check("async_pre_tvalid", tvalid, 1'b1);
        #3 reset = 1'b0;
        #1;
        check_idle("async_reset");
        check("async_fin",    finSend, 1'b0);
        check("async_lenerr", lenErr,  1'b0);
        #2 reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
